hash_round_engine: RTL and testbench
====================================

Name: hash_round_engine

Overview:
- Iterative, parametrised round engine for the toy hash datapath.
- Holds a 3-word state (a, b, c) and applies ROUNDS sequential rounds, one per accepted schedule word W.
- Supports both round flavours, XOR-mix with constant K1 and OR-mix with constant K2, selected per round index.
- Sits between the message-schedule streamer, which supplies W, and the nonce-search controller, which issues start and consumes the result.

Parameters:
- WIDTH, 8: word width in bits; must be even and ≥4.
- ROUNDS, 32: rounds per block; must be ≥1.
- SPLIT, ROUNDS/2: rounds with index < SPLIT use the XOR flavour; the rest use the OR flavour.
- K1, 'h99: XOR-flavour round constant, WIDTH bits, zero-extended.
- K2, 'hA1: OR-flavour round constant, WIDTH bits, zero-extended.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; loads a_in/b_in/c_in when idle.
- a_in  in  WIDTH  initial a.
- b_in  in  WIDTH  initial b.
- c_in  in  WIDTH  initial c.
- w_valid  in  1  schedule word available.
- w_data  in  WIDTH  schedule word W.
- w_ready  out  1  engine accepts W this cycle.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse, result valid.
- round_idx  out  clog2(ROUNDS+1)  rounds completed in the current block.
- a_out  out  WIDTH  result a, held until next start.
- b_out  out  WIDTH  result b, held until next start.
- c_out  out  WIDTH  result c, held until next start.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state=IDLE; a/b/c registers, outputs, round_idx, done, busy and w_ready all 0. Reset mid-block aborts with no done pulse.
- FSM IDLE: start=1 loads a,b,c from the inputs, sets round_idx=0, goes to RUN. start=0 holds.
- FSM RUN: w_ready=1. On w_valid&&w_ready, apply one round and increment round_idx. w_valid=0 stalls with state unchanged. When the ROUNDS-th word is accepted, go to DONE.
- FSM DONE: done=1 for exactly one cycle; a_out/b_out/c_out update on entry to DONE; w_ready=0; next state IDLE.
- start is ignored in RUN and DONE; no queueing.
- Round i, with r = round_idx before the increment:
  - x = (r<SPLIT) ? a^b : a|b
  - a' = b^c
  - b' = c << (WIDTH/2), zero fill, truncated to WIDTH
  - c' = x + ((r<SPLIT)?K1:K2) + W, modulo 2^WIDTH, carries discarded
- All of a', b', c' are computed from pre-round values; no intra-round forwarding.
- Latency: start accepted at edge T0, words accepted at edges T1..TROUNDS with continuous w_valid, done high in the cycle after edge TROUNDS. Minimum block time is ROUNDS+2 cycles from start to return to IDLE.
- Boundary SPLIT=0: all rounds use OR. SPLIT≥ROUNDS: all rounds use XOR.
- Boundary ROUNDS=1: RUN lasts until the single word is accepted.
- Outputs keep the last result through IDLE and RUN of the next block; they change only on DONE entry.

Optional Feature:
- Macro: HASH_FEEDFWD_EN.
- Defined: on DONE entry, a_out=a_final+a_init, b_out=b_final+b_init, c_out=c_final+c_init, each modulo 2^WIDTH. Initial values are latched at start.
- Undefined: outputs are the raw final state. No init registers are synthesised.

Test Plan:
- Test 1, reset: assert rst_n=0 mid-RUN at round 3 → all outputs 0 immediately, no done, IDLE after release.
- Test 2, zero block: WIDTH=8, ROUNDS=2, a/b/c=0, W=0,0 → done with a_out=0x99, b_out=0x90, c_out=0xA1.
- Test 3, mixed block: ROUNDS=2, a=0x0F, b=0xF0, c=0x00, W=0x01,0x02 → (0x99,0x90,0x93). With HASH_FEEDFWD_EN → (0xA8,0x80,0x93).
- Test 4, stall: same as Test 3 but w_valid low 3 cycles between words → identical result, done 3 cycles later, round_idx holds at 1 during the stall.
- Test 5, start ignored: start pulsed during RUN and DONE → ignored, result unchanged, exactly one done pulse; a start on the following IDLE cycle begins a new block.
- Test 6, default block: default parameters (ROUNDS=32, SPLIT=16) → round_idx counts 0..32, busy high ROUNDS+1 cycles with continuous w_valid, result matches the reference model.

Source files
------------

// File: rtl/hash_round_engine.sv
// Iterative 3-word toy-hash round engine: one round per accepted schedule word.
// Optional HASH_FEEDFWD_EN adds the block's initial a/b/c into the result.
module hash_round_engine #(
  parameter int              WIDTH  = 8,
  parameter int              ROUNDS = 32,
  parameter int              SPLIT  = ROUNDS / 2,
  parameter logic [WIDTH-1:0] K1    = 'h99,
  parameter logic [WIDTH-1:0] K2    = 'hA1,
  localparam int             RW     = $clog2(ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic             w_valid,
  input  logic [WIDTH-1:0] w_data,
  output logic             w_ready,
  output logic             busy,
  output logic             done,
  output logic [RW-1:0]    round_idx,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a, b, c;
  logic [WIDTH-1:0] x, na, nb, nc, ra, rb, rc;
  logic             xor_flav, last;

`ifdef HASH_FEEDFWD_EN
  logic [WIDTH-1:0] a_init, b_init, c_init;
`endif

  // Flavour is picked from the completed-round count before this round's increment.
  assign xor_flav = int'(round_idx) < SPLIT;
  assign last     = round_idx == RW'(ROUNDS - 1);

  always_comb begin
    x  = xor_flav ? (a ^ b) : (a | b);
    na = b ^ c;
    nb = c << (WIDTH / 2);
    nc = x + (xor_flav ? K1 : K2) + w_data;
`ifdef HASH_FEEDFWD_EN
    ra = na + a_init;
    rb = nb + b_init;
    rc = nc + c_init;
`else
    ra = na;
    rb = nb;
    rc = nc;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      round_idx <= '0;
      w_ready   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      c_out     <= '0;
`ifdef HASH_FEEDFWD_EN
      a_init    <= '0;
      b_init    <= '0;
      c_init    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a         <= a_in;
          b         <= b_in;
          c         <= c_in;
          round_idx <= '0;
          w_ready   <= 1'b1;
          busy      <= 1'b1;
          state     <= RUN;
`ifdef HASH_FEEDFWD_EN
          a_init    <= a_in;
          b_init    <= b_in;
          c_init    <= c_in;
`endif
        end
        RUN: if (w_valid) begin
          a         <= na;
          b         <= nb;
          c         <= nc;
          round_idx <= round_idx + RW'(1);
          // The final round's result goes straight to the outputs as DONE is entered.
          if (last) begin
            w_ready <= 1'b0;
            done    <= 1'b1;
            a_out   <= ra;
            b_out   <= rb;
            c_out   <= rc;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_round_engine.sv
// Scoreboarded bench: a ROUNDS=2 instance (u0) and a default ROUNDS=32 instance (u1).
module tb_hash_round_engine;

  typedef struct packed {logic [7:0] a, b, c;} res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       start, w_valid, w_ready, busy, done;
  logic [1:0][7:0]  a_in, b_in, c_in, w_data, a_out, b_out, c_out;
  logic [1:0]       ridx0;
  logic [5:0]       ridx1;

  res_t q0[$], q1[$];
  res_t last_r[2];
  int   done_cnt[2];
  int   errors = 0, checks = 0;

  always #5 clk = ~clk;

  hash_round_engine #(.WIDTH(8), .ROUNDS(2), .SPLIT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a_in(a_in[0]), .b_in(b_in[0]),
    .c_in(c_in[0]), .w_valid(w_valid[0]), .w_data(w_data[0]), .w_ready(w_ready[0]),
    .busy(busy[0]), .done(done[0]), .round_idx(ridx0), .a_out(a_out[0]),
    .b_out(b_out[0]), .c_out(c_out[0]));

  hash_round_engine dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a_in(a_in[1]), .b_in(b_in[1]),
    .c_in(c_in[1]), .w_valid(w_valid[1]), .w_data(w_data[1]), .w_ready(w_ready[1]),
    .busy(busy[1]), .done(done[1]), .round_idx(ridx1), .a_out(a_out[1]),
    .b_out(b_out[1]), .c_out(c_out[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int ridx(input int u);
    return (u == 0) ? int'(ridx0) : int'(ridx1);
  endfunction

  // Reference: rounds applied straight from the algorithm definition.
  function automatic res_t model(input logic [7:0] a0, b0, c0, input logic [7:0] w[32],
                                 input int rounds, input int split);
    logic [7:0] a = a0, b = b0, c = c0, x, k, na, nc;
    for (int r = 0; r < rounds; r++) begin
      x  = (r < split) ? (a ^ b) : (a | b);
      k  = (r < split) ? 8'h99 : 8'hA1;
      na = b ^ c;
      nc = 8'(x + k + w[r]);
      b  = {c[3:0], 4'h0};
      c  = nc;
      a  = na;
    end
`ifdef HASH_FEEDFWD_EN
    a = a + a0;
    b = b + b0;
    c = c + c0;
`endif
    return '{a: a, b: b, c: c};
  endfunction

  // Monitor: pop on every done pulse, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    res_t got, exp;
    if (rst_n) begin
      for (int u = 0; u < 2; u++) begin
        got = '{a: a_out[u], b: b_out[u], c: c_out[u]};
        if (done[u]) begin
          done_cnt[u]++;
          if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
            chk("unexpected_done", 32'(u), 32'hFFFF);
          end else begin
            exp = (u == 0) ? q0.pop_front() : q1.pop_front();
            chk(u == 0 ? "result_u0" : "result_u1", 32'(got), 32'(exp));
            last_r[u] = exp;
          end
        end else if (got !== last_r[u]) begin
          chk(u == 0 ? "hold_u0" : "hold_u1", 32'(got), 32'(last_r[u]));
        end
      end
    end
  end

  // gap_mode: 0 none, 1 random 0..3 stalls, 2 fixed 3-cycle stall between words.
  task automatic run_block(input int u, input logic [7:0] a, b, c, input logic [7:0] w[32],
                           input int gap_mode, input bit poke, input res_t exp);
    int rounds = (u == 0) ? 2 : 32;
    int bc = 0, gaps = 0, n = 0, g;
    while (busy[u] && n < 200) begin @(posedge clk); #1; n++; end
    chk("idle_wait", 32'(busy[u]), 0);
    start[u] = 1'b1; a_in[u] = a; b_in[u] = b; c_in[u] = c;
    if (u == 0) q0.push_back(exp); else q1.push_back(exp);
    @(posedge clk); #1;
    start[u] = 1'b0;
    chk("start_ridx", 32'(ridx(u)), 0);
    for (int i = 0; i < rounds; i++) begin
      g = (gap_mode == 1) ? int'($urandom_range(0, 3)) : (gap_mode == 2 && i > 0) ? 3 : 0;
      for (int k = 0; k < g; k++) begin
        bc += int'(busy[u]); gaps++;
        w_valid[u] = 1'b0; w_data[u] = 8'($urandom);
        start[u] = poke; a_in[u] = 8'($urandom);
        @(posedge clk); #1;
        start[u] = 1'b0;
        chk("stall_ridx", 32'(ridx(u)), 32'(i));
      end
      bc += int'(busy[u]);
      chk("w_ready", 32'(w_ready[u]), 1);
      chk("ridx", 32'(ridx(u)), 32'(i));
      w_valid[u] = 1'b1; w_data[u] = w[i]; start[u] = poke;
      @(posedge clk); #1;
      w_valid[u] = 1'b0; start[u] = 1'b0;
    end
    bc += int'(busy[u]);
    chk("final_ridx", 32'(ridx(u)), 32'(rounds));
    chk("done_wready", 32'(w_ready[u]), 0);
    chk("done_pulse", 32'(done[u]), 1);
    start[u] = poke; a_in[u] = 8'($urandom);
    @(posedge clk); #1;
    start[u] = 1'b0;
    chk("busy_cycles", 32'(bc), 32'(rounds + gaps + 1));
    chk("back_idle", 32'(busy[u] | done[u]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] w[32];
    logic [7:0] a, b, c;
    res_t e;
    int d1;
    rst_n = 1'b0; start = '0; w_valid = '0;
    a_in = '0; b_in = '0; c_in = '0; w_data = '0;
    last_r[0] = '0; last_r[1] = '0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 32'({a_out, b_out, c_out}), 0);
    chk("rst_ctl", 32'({busy, done, w_ready, ridx0, ridx1}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero block
    w = '{default: 8'h00};
`ifdef HASH_FEEDFWD_EN
    e = '{a: 8'h99, b: 8'h90, c: 8'hA1};
`else
    e = '{a: 8'h99, b: 8'h90, c: 8'hA1};
`endif
    run_block(0, 8'h00, 8'h00, 8'h00, w, 0, 1'b0, e);

    // mixed block, then the same with a 3-cycle stall between words
    w[0] = 8'h01; w[1] = 8'h02;
`ifdef HASH_FEEDFWD_EN
    e = '{a: 8'hA8, b: 8'h80, c: 8'h93};
`else
    e = '{a: 8'h99, b: 8'h90, c: 8'h93};
`endif
    run_block(0, 8'h0F, 8'hF0, 8'h00, w, 0, 1'b0, e);
    run_block(0, 8'h0F, 8'hF0, 8'h00, w, 2, 1'b0, e);

    // start pokes during RUN/DONE, followed by an immediate new block
    run_block(0, 8'h0F, 8'hF0, 8'h00, w, 1, 1'b1, e);
    w[0] = 8'h5A; w[1] = 8'hC3;
    run_block(0, 8'h12, 8'h34, 8'h56, w, 0, 1'b0, model(8'h12, 8'h34, 8'h56, w, 2, 1));

    // reset mid-block at round 3
    d1 = done_cnt[1];
    start[1] = 1'b1; a_in[1] = 8'hAB; b_in[1] = 8'hCD; c_in[1] = 8'hEF;
    @(posedge clk); #1;
    start[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_valid[1] = 1'b1; w_data[1] = 8'($urandom);
      @(posedge clk); #1;
    end
    w_valid[1] = 1'b0;
    chk("pre_rst_ridx", 32'(ridx1), 3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", 32'({a_out[1], b_out[1], c_out[1]}), 0);
    chk("rst_mid_ctl", 32'({busy[1], done[1], w_ready[1], ridx1}), 0);
    last_r[0] = '0; last_r[1] = '0;
    q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle", 32'(busy[1]), 0);
    chk("rst_no_done", 32'(done_cnt[1]), 32'(d1));

    // randomized blocks on both instances
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 32; i++) w[i] = 8'($urandom);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      run_block(1, a, b, c, w, (blk == 0) ? 0 : 1, blk[0], model(a, b, c, w, 32, 16));
    end
    for (int blk = 0; blk < 12; blk++) begin
      w[0] = 8'($urandom); w[1] = 8'($urandom);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      run_block(0, a, b, c, w, blk % 3, blk[1], model(a, b, c, w, 2, 1));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("done_cnt_u0", 32'(done_cnt[0]), 17);
    chk("done_cnt_u1", 32'(done_cnt[1]), 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
